// File: rtl/buzzer_tone_decoder.sv
// Measures the period of a square-wave tone and locks onto a musical note
// once CONFIRM consecutive periods classify to the same note.
module buzzer_tone_decoder #(
  parameter logic [17:0] DO        = 18'd190840,
  parameter logic [17:0] RE        = 18'd170068,
  parameter logic [17:0] MI        = 18'd151515,
  parameter logic [17:0] FA        = 18'd143266,
  parameter logic [17:0] SO        = 18'd127551,
  parameter logic [17:0] LA        = 18'd113636,
  parameter logic [17:0] XI        = 18'd101214,
  parameter logic [17:0] TOLERANCE = 18'd1024,
  parameter logic [17:0] TIMEOUT   = 18'd250000,
  parameter logic [2:0]  CONFIRM   = 3'd3
) (
  input  logic        system_clock,
  input  logic        system_reset_n,
  input  logic        tone_in,
  output logic [2:0]  note_code,
  output logic        note_valid,
  output logic        note_change,
  output logic [17:0] period_out,
  output logic        period_strobe
);

  typedef enum logic [1:0] {SILENT, ARMED, LOCKED} state_t;

  localparam logic [6:0][17:0] NOTES = {XI, LA, SO, FA, MI, RE, DO};
  localparam logic [2:0]       NONE  = 3'd7;

  state_t      state, state_nxt;
  logic [2:0]  sync_q;
  logic        edge_p;
  logic [17:0] elapsed;
  logic [2:0]  cls;
  logic [2:0]  cand, cand_nxt, match_cnt, match_nxt, code_nxt;
  logic        valid_nxt, strobe_nxt;
  logic [17:0] period_nxt;

  function automatic logic [17:0] absdiff(input logic [17:0] a, input logic [17:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // sync_q[1:0] is the synchronizer, sync_q[2] the previous synchronized level;
  // edge_p is registered so tone_in -> edge pulse is exactly 3 cycles.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sync_q  <= '0;
      edge_p  <= 1'b0;
      elapsed <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tone_in};
      edge_p <= sync_q[1] & ~sync_q[2];
      if (edge_p)                 elapsed <= 18'd1;
      else if (elapsed < TIMEOUT) elapsed <= elapsed + 18'd1;
    end
  end

  // Scan from XI down to DO so the earliest note in DO..XI order wins.
  always_comb begin
    cls = NONE;
    for (int i = 6; i >= 0; i--)
      if (absdiff(elapsed, NOTES[i]) <= TOLERANCE) cls = 3'(i);
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    match_nxt  = match_cnt;
    code_nxt   = note_code;
    valid_nxt  = note_valid;
    strobe_nxt = 1'b0;
    period_nxt = period_out;
    case (state)
      SILENT: if (edge_p) begin
        state_nxt = ARMED;
        cand_nxt  = NONE;
        match_nxt = '0;
      end
      ARMED: if (edge_p) begin
        strobe_nxt = 1'b1;
        period_nxt = elapsed;
        if (cls == NONE) begin
          cand_nxt  = NONE;
          match_nxt = '0;
        end else if (cls == cand) begin
          match_nxt = match_cnt + 3'd1;
        end else begin
          cand_nxt  = cls;
          match_nxt = 3'd1;
        end
        if (cls != NONE && match_nxt == CONFIRM) begin
          state_nxt = LOCKED;
          code_nxt  = cand_nxt;
          valid_nxt = 1'b1;
        end
      end else if (elapsed >= TIMEOUT) begin
        state_nxt = SILENT;
        code_nxt  = NONE;
        valid_nxt = 1'b0;
      end
      LOCKED: if (edge_p) begin
        strobe_nxt = 1'b1;
        period_nxt = elapsed;
        if (cls != note_code) begin
          state_nxt = ARMED;
          code_nxt  = NONE;
          valid_nxt = 1'b0;
          cand_nxt  = cls;
          match_nxt = (cls == NONE) ? 3'd0 : 3'd1;
        end
      end else if (elapsed >= TIMEOUT) begin
        state_nxt = SILENT;
        code_nxt  = NONE;
        valid_nxt = 1'b0;
      end
      default: state_nxt = SILENT;
    endcase
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state         <= SILENT;
      cand          <= NONE;
      match_cnt     <= '0;
      note_code     <= NONE;
      note_valid    <= 1'b0;
      note_change   <= 1'b0;
      period_out    <= '0;
      period_strobe <= 1'b0;
    end else begin
      state         <= state_nxt;
      cand          <= cand_nxt;
      match_cnt     <= match_nxt;
      note_code     <= code_nxt;
      note_valid    <= valid_nxt;
      note_change   <= (code_nxt != note_code);
      period_out    <= period_nxt;
      period_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_buzzer_tone_decoder.sv
// Scoreboard bench for buzzer_tone_decoder with note periods scaled down ~100x
// so every scenario fits in a short run.
module tb_buzzer_tone_decoder;

  localparam logic [17:0] P_DO = 18'd1908, P_RE = 18'd1700, P_MI = 18'd1515,
                          P_FA = 18'd1432, P_SO = 18'd1275, P_LA = 18'd1136,
                          P_XI = 18'd1012, P_TOL = 18'd10, P_TO = 18'd2500;

  logic        system_clock = 1'b0;
  logic        system_reset_n = 1'b0;
  logic        tone_in = 1'b0;
  logic [2:0]  note_code;
  logic        note_valid, note_change, period_strobe;
  logic [17:0] period_out;

  buzzer_tone_decoder #(
    .DO(P_DO), .RE(P_RE), .MI(P_MI), .FA(P_FA), .SO(P_SO), .LA(P_LA), .XI(P_XI),
    .TOLERANCE(P_TOL), .TIMEOUT(P_TO), .CONFIRM(3'd3)
  ) dut (
    .system_clock(system_clock), .system_reset_n(system_reset_n), .tone_in(tone_in),
    .note_code(note_code), .note_valid(note_valid), .note_change(note_change),
    .period_out(period_out), .period_strobe(period_strobe)
  );

  always #5 system_clock = ~system_clock;

  typedef struct {
    logic [17:0] period;
    logic [2:0]  code;
    logic        valid;
    logic        change;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc_no = 0, strobe_cyc = 0, valid_fall_cyc = 0;
  int   chg_cnt = 0, strobe_cnt = 0;
  int   hi_len = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  // Next rising edge lands exactly p cycles after the previous one; ~50% duty.
  task automatic edge_after(input int p, input bit push, input logic [2:0] c,
                            input logic v, input logic ch);
    exp_t e;
    tone_in = 1'b0;
    cyc(p - hi_len);
    if (push) begin
      e.period = 18'(p); e.code = c; e.valid = v; e.change = ch;
      sb.push_back(e);
    end
    tone_in = 1'b1;
    hi_len  = p / 2;
    cyc(hi_len);
  endtask

  // Three periods of one note from an armed state: lock on the third.
  task automatic lock_seq(input int p, input logic [2:0] c, input logic first_change);
    edge_after(p, 1'b1, 3'd7, 1'b0, first_change);
    edge_after(p, 1'b1, 3'd7, 1'b0, 1'b0);
    edge_after(p, 1'b1, c, 1'b1, 1'b1);
  endtask

  always @(negedge system_clock) begin
    exp_t e;
    cyc_no++;
    if (note_change) chg_cnt++;
    if (prev_valid && !note_valid) valid_fall_cyc = cyc_no;
    prev_valid = note_valid;
    if (period_strobe) begin
      strobe_cnt++;
      strobe_cyc = cyc_no;
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("period", 32'(period_out), 32'(e.period));
        chk("code",   32'(note_code),  32'(e.code));
        chk("valid",  32'(note_valid), 32'(e.valid));
        chk("change", 32'(note_change), 32'(e.change));
      end
    end
  end

  initial begin
    int c0, s0, k;
    // Reset held: tone toggling must not disturb anything.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) tone_in = ~tone_in;
      cyc(1);
      if (i % 4 == 3) begin
        chk("rst_code",   32'(note_code), 32'd7);
        chk("rst_valid",  32'(note_valid), 32'd0);
        chk("rst_period", 32'(period_out), 32'd0);
        chk("rst_strobe", 32'(period_strobe), 32'd0);
        chk("rst_change", 32'(note_change), 32'd0);
      end
    end
    tone_in = 1'b0;
    cyc(3);
    system_reset_n = 1'b1;
    cyc(5);

    // MI lock: reference edge, strobes on edges 2-4, lock on 4
    c0 = chg_cnt;
    edge_after(100, 1'b0, 3'd0, 1'b0, 1'b0);
    lock_seq(P_MI, 3'd2, 1'b0);
    chk("mi_single_change", 32'(chg_cnt - c0), 32'd1);
    edge_after(P_MI, 1'b1, 3'd2, 1'b1, 1'b0);

    // FA boundary: FA+TOL locks to 3, FA+TOL+1 unlocks and never locks
    lock_seq(P_FA + P_TOL, 3'd3, 1'b1);
    edge_after(P_FA + P_TOL + 1, 1'b1, 3'd7, 1'b0, 1'b1);
    c0 = chg_cnt;
    for (int i = 0; i < 3; i++) edge_after(P_FA + P_TOL + 1, 1'b1, 3'd7, 1'b0, 1'b0);
    chk("fa_over_no_change", 32'(chg_cnt - c0), 32'd0);
    chk("fa_over_valid", 32'(note_valid), 32'd0);

    // Note switch DO -> RE
    lock_seq(P_DO, 3'd0, 1'b0);
    lock_seq(P_RE, 3'd1, 1'b1);

    // Timeout after LA lock
    lock_seq(P_LA, 3'd5, 1'b1);
    tone_in = 1'b0;
    c0 = chg_cnt;
    k = 0;
    while (note_valid && k < int'(P_TO) + 200) begin cyc(1); k++; end
    cyc(2);
    chk("to_valid", 32'(note_valid), 32'd0);
    chk("to_code", 32'(note_code), 32'd7);
    chk("to_delay", 32'(valid_fall_cyc - strobe_cyc), 32'(P_TO));
    chk("to_change", 32'(chg_cnt - c0), 32'd1);
    c0 = chg_cnt; s0 = strobe_cnt;
    cyc(3000);
    chk("silent_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("silent_no_change", 32'(chg_cnt - c0), 32'd0);

    // Mid-lock reset on SO, then relock from scratch
    hi_len = 0;
    edge_after(P_SO, 1'b0, 3'd0, 1'b0, 1'b0);
    lock_seq(P_SO, 3'd4, 1'b0);
    chk("so_locked", 32'(note_code), 32'd4);
    tone_in = 1'b0;
    cyc(20);
    #3 system_reset_n = 1'b0;
    #1;
    chk("mrst_code",   32'(note_code), 32'd7);
    chk("mrst_valid",  32'(note_valid), 32'd0);
    chk("mrst_period", 32'(period_out), 32'd0);
    chk("mrst_change", 32'(note_change), 32'd0);
    cyc(5);
    system_reset_n = 1'b1;
    hi_len = 0;
    c0 = chg_cnt;
    edge_after(P_SO, 1'b0, 3'd0, 1'b0, 1'b0);
    lock_seq(P_SO, 3'd4, 1'b0);
    chk("relock_change", 32'(chg_cnt - c0), 32'd1);
    chk("relock_valid", 32'(note_valid), 32'd1);

    cyc(10);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
